pipelined_add_sub: RTL and testbench
====================================

// Module: pipelined_add_sub
// PURPOSE
//  - Parametrised, pipelined add/subtract unit; successor to the single-bit full-adder cell.
//  - Splits a WIDTH-bit operation into STAGES = WIDTH/CHUNK carry-chained slices, one slice per cycle.
//  - Valid/ready stream handshake on input and output with full backpressure; feeds the ALU datapath.
// PARAMETERS
//  - WIDTH   8  operand/result width in bits; must be a multiple of CHUNK (elaboration error otherwise)
//  - CHUNK   4  bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (1 => single registered stage)
// PORTS
//  - clk        in   1      single clock, rising edge
//  - rst_n      in   1      synchronous, active-low reset
//  - in_valid   in   1      operand beat valid
//  - in_ready   out  1      unit can accept a beat this cycle
//  - in_a       in   WIDTH  operand A
//  - in_b       in   WIDTH  operand B
//  - in_sub     in   1      0: A+B+cin   1: A+~B+1 (cin ignored)
//  - in_cin     in   1      carry in for add mode
//  - out_valid  out  1      result beat valid
//  - out_ready  in   1      downstream accepts result
//  - out_sum    out  WIDTH  result
//  - out_cout   out  1      carry out of MSB (in sub mode: 1 = no borrow)
// BEHAVIOUR
//  - Transfer occurs on a rising edge where valid && ready (both sides).
//  - Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] with carry from stage k-1's register.
//  - Upper operand slices are skewed (delayed) into their stage; lower result slices deskewed so all of out_sum leaves together.
//  - Latency: STAGES cycles from input handshake to out_valid with out_ready held high; throughput 1 beat/cycle.
//  - Per-stage ready: stage_ready[k] = !stage_valid[k] || stage_ready[k+1]; in_ready = stage_ready[0]; last stage uses out_ready.
//  - Bubbles collapse: an empty stage accepts data even when downstream is stalled.
//  - Stall: out_valid held and out_sum/out_cout stable until out_ready; no beat dropped or duplicated.
//  - Full pipeline + out_ready=0: in_ready=0 combinationally in the same cycle.
//  - Full pipeline + out_ready=1: accepts a new beat in the same cycle one leaves (no bubble).
//  - Arithmetic is modulo 2^WIDTH; carry beyond MSB reported only on out_cout.
//  - Reset (rst_n=0 at edge): all stage valids 0, out_valid=0, out_sum=0, out_cout=0; in_ready=1 the cycle after.
//    In-flight beats are discarded, never emitted.
//  - No FSM beyond per-stage valid bits; stage data regs load only when the stage advances.
// CONFIGURATION
//  - Macro PIPELINED_ADD_SUB_FLAGS_EN:
//    defined:     adds outputs out_ovf (signed overflow), out_zero (out_sum==0), out_neg (out_sum[MSB]),
//                 all 1 bit, aligned with out_sum, reset to 0.
//    not defined: these ports and their logic do not exist; other behaviour identical.
// STRUCTURE
//  - Shared package alu_pkg: localparam helpers (STAGES calc), op-mode encoding constants (OP_ADD=0, OP_SUB=1).
//  - One sub-module: add_slice (CHUNK-bit combinational carry chain with P/G per bit, cin -> sum, cout);
//    instantiated STAGES times via generate.
//  - Top holds skew/deskew shift regs, stage valid bits, handshake logic.
// TESTING
//  - WIDTH=8,CHUNK=4, out_ready=1: A=0x7F,B=0x01,add,cin=0 -> after 2 cycles sum=0x80,cout=0 (ovf=1,neg=1 if FLAGS_EN).
//  - Sub: A=0x05,B=0x07 -> sum=0xFE,cout=0; A=0x07,B=0x05 -> sum=0x02,cout=1; A=B=0x33 -> sum=0x00,cout=1 (zero=1).
//  - Carry across slice boundary: A=0xFF,B=0x00,cin=1 -> sum=0x00,cout=1.
//  - Back-to-back 100 random beats with random out_ready stalls -> results match model, in order, none lost/duplicated.
//  - Fill pipeline with out_ready=0 -> in_ready=0 after STAGES accepts; raise out_ready -> one result/cycle.
//  - Assert rst_n=0 with 2 beats in flight -> out_valid=0 next cycle, no stale result ever emitted; CHUNK=WIDTH=8 latency=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and helpers for the pipelined ALU datapath
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - W-bit combinational ripple slice built from per-bit propagate/generate
module add_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - carry-chained add/sub pipeline with valid/ready; PIPELINED_ADD_SUB_FLAGS_EN adds ovf/zero/neg
module pipelined_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef PIPELINED_ADD_SUB_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
`endif
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("pipelined_add_sub: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Per-stage inputs: index k is what stage k consumes this cycle.
    logic [WIDTH-1:0]  a_in   [STAGES];
    logic [WIDTH-1:0]  b_in   [STAGES];
    logic [WIDTH-1:0]  s_in   [STAGES];
    logic [WIDTH-1:0]  s_next [STAGES];
    logic [WIDTH-1:0]  s_q    [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] dn_rdy;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] slice_cout;

    // Subtract folds into the first slice as A + ~B + 1.
    assign a_in[0] = in_a;
    assign b_in[0] = (in_sub == OP_SUB) ? ~in_b : in_b;
    assign s_in[0] = '0;
    assign c_in[0] = (in_sub == OP_SUB) ? 1'b1 : in_cin;
    assign v_in[0] = in_valid;

    // Ready ripples back from out_ready so a full pipe still accepts while draining.
    always_comb begin : p_ready
        logic r;
        rdy    = '0;
        dn_rdy = '0;
        r      = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            dn_rdy[k] = r;
            r         = !v_q[k] || r;
            rdy[k]    = r;
        end
    end

    assign load = rdy & v_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

        logic [CHUNK-1:0] slice_sum;
        logic             v_r;
        logic             c_r;
        logic [WIDTH-1:0] s_r;

        add_slice #(
            .W(CHUNK)
        ) u_slice (
            .a   (a_in[k][k*CHUNK +: CHUNK]),
            .b   (b_in[k][k*CHUNK +: CHUNK]),
            .cin (c_in[k]),
            .sum (slice_sum),
            .cout(slice_cout[k])
        );

        assign s_next[k] = (s_in[k] & ~MASK) | (WIDTH'(slice_sum) << (k * CHUNK));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else begin
                v_r <= load[k] | (v_r & ~dn_rdy[k]);
                if (load[k]) begin
                    s_r <= s_next[k];
                    c_r <= slice_cout[k];
                end
            end
        end

        assign v_q[k] = v_r;
        assign c_q[k] = c_r;
        assign s_q[k] = s_r;

        // Operands ride along until their slice is reached; finished slices ride to the output.
        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;

            always_ff @(posedge clk) begin
                if (load[k]) begin
                    a_r <= a_in[k];
                    b_r <= b_in[k];
                end
            end

            assign a_in[k+1] = a_r;
            assign b_in[k+1] = b_r;
            assign s_in[k+1] = s_r;
            assign c_in[k+1] = c_r;
            assign v_in[k+1] = v_r;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign out_sum   = s_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];

`ifdef PIPELINED_ADD_SUB_FLAGS_EN
    localparam int LAST = STAGES - 1;

    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] fin;
    logic             ovf_r;
    logic             zero_r;
    logic             neg_r;

    assign a_msb = a_in[LAST][WIDTH-1];
    assign b_msb = b_in[LAST][WIDTH-1];
    assign fin   = s_next[LAST];

    // Flags are registered alongside the final slice so they reset to 0 and stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else if (load[LAST]) begin
            ovf_r  <= (a_msb == b_msb) && (fin[WIDTH-1] != a_msb);
            zero_r <= (fin == '0);
            neg_r  <= fin[WIDTH-1];
        end
    end

    assign out_ovf  = ovf_r;
    assign out_zero = zero_r;
    assign out_neg  = neg_r;
`endif

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - scoreboard bench for pipelined_add_sub (2-stage and 1-stage builds)
module tb_pipelined_add_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_sub, in_cin;
    logic [7:0] in_a, in_b;
    logic       out_valid, out_ready, out_cout;
    logic [7:0] out_sum;

    logic       d1_in_valid, d1_in_ready, d1_in_sub, d1_in_cin;
    logic [7:0] d1_in_a, d1_in_b;
    logic       d1_out_valid, d1_out_ready, d1_out_cout;
    logic [7:0] d1_out_sum;
`ifdef PIPELINED_ADD_SUB_FLAGS_EN
    logic       out_ovf, out_zero, out_neg;
    logic       d1_out_ovf, d1_out_zero, d1_out_neg;
`endif

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
        logic       neg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic or_rand = 1'b0;
    logic or_val  = 1'b1;

    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
`ifdef PIPELINED_ADD_SUB_FLAGS_EN
        , .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg)
`endif
    );

    pipelined_add_sub #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_a(d1_in_a), .in_b(d1_in_b),
        .in_sub(d1_in_sub), .in_cin(d1_in_cin),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_sum(d1_out_sum), .out_cout(d1_out_cout)
`ifdef PIPELINED_ADD_SUB_FLAGS_EN
        , .out_ovf(d1_out_ovf), .out_zero(d1_out_zero), .out_neg(d1_out_neg)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o, input logic z, input logic n);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.neg = n;
        return e;
    endfunction

    // Reference via signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
        int ua, ub, sa, sb, u, s;
        exp_t e;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        if (sub) begin
            u = ua - ub; s = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            u = ua + ub + int'(cin); s = sa + sb + int'(cin);
            e.cout = (u > 255);
        end
        e.sum  = u[7:0];
        e.ovf  = (s > 127) || (s < -128);
        e.zero = (u[7:0] == 8'h00);
        e.neg  = u[7];
        return e;
    endfunction

    // Called on a negedge; returns on the negedge after the handshake edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin,
                        input exp_t e, output int waited);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_cin = cin;
        waited = 0;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!in_ready) check("send_timeout", 32'(waited), 32'd0);
        else q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_val;
        end
    end

    initial begin : monitor
        logic        stalled;
        logic [8:0]  held;
        exp_t        e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_hold", 32'({out_sum, out_cout}), 32'(held));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got sum=%0h, required no output", out_sum);
                    end else begin
                        e = q.pop_front();
                        check("sum", 32'(out_sum), 32'(e.sum));
                        check("cout", 32'(out_cout), 32'(e.cout));
`ifdef PIPELINED_ADD_SUB_FLAGS_EN
                        check("flags", 32'({out_ovf, out_zero, out_neg}), 32'({e.ovf, e.zero, e.neg}));
`endif
                    end
                end
                stalled = out_valid && !out_ready;
                held    = {out_sum, out_cout};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin : stim
        int w;
        logic [7:0] ra, rb;
        logic rs, rc;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
        d1_in_valid = 1'b0; d1_in_a = '0; d1_in_b = '0; d1_in_sub = 1'b0; d1_in_cin = 1'b0;
        d1_out_ready = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'({out_sum, out_cout}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPELINED_ADD_SUB_FLAGS_EN
        check("rst_flags", 32'({out_ovf, out_zero, out_neg}), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Latency of the 2-stage build.
        send(8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1, 1'b0, 1'b1), w);
        #3 check("lat_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        #3 check("lat_on_time", 32'(out_valid), 32'd1);
        @(negedge clk);

        // Directed vectors, back to back.
        send(8'h05, 8'h07, 1'b1, 1'b0, mk(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1), w);
        send(8'h07, 8'h05, 1'b1, 1'b0, mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b0), w);
        send(8'h33, 8'h33, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0), w);
        send(8'hFF, 8'h00, 1'b0, 1'b1, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0), w);
        send(8'h80, 8'h01, 1'b1, 1'b0, mk(8'h7F, 1'b1, 1'b1, 1'b0, 1'b0), w);
        send(8'hAA, 8'h55, 1'b0, 1'b0, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1), w);
        send(8'h10, 8'h01, 1'b1, 1'b1, mk(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0), w);
        send(8'h0F, 8'h01, 1'b0, 1'b0, mk(8'h10, 1'b0, 1'b0, 1'b0, 1'b0), w);
        drain("drain_directed");

        // Random beats under random backpressure.
        or_rand = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            send(ra, rb, rs, rc, model(ra, rb, rs, rc), w);
        end
        or_rand = 1'b0;
        or_val  = 1'b1;
        drain("drain_random");

        // Fill with out_ready low, then release.
        #4 or_val = 1'b0;
        @(negedge clk);
        send(8'h01, 8'h02, 1'b0, 1'b0, mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0), w);
        send(8'h10, 8'h20, 1'b0, 1'b0, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0), w);
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        #3 or_val = 1'b1;
        @(negedge clk);
        send(8'hF0, 8'h0F, 1'b0, 1'b0, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1), w);
        check("full_accept_wait", 32'(w), 32'd0);
        #3 check("no_bubble_1", 32'(out_valid), 32'd1);
        @(negedge clk);
        #3 check("no_bubble_2", 32'(out_valid), 32'd1);
        @(negedge clk);
        drain("drain_fill");

        // Reset with beats in flight: nothing stale may appear afterwards.
        #4 or_val = 1'b0;
        @(negedge clk);
        send(8'h11, 8'h11, 1'b0, 1'b0, mk(8'h22, 1'b0, 1'b0, 1'b0, 1'b0), w);
        send(8'h22, 8'h22, 1'b0, 1'b0, mk(8'h44, 1'b0, 1'b0, 1'b0, 1'b0), w);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        #1;
        check("rst_flight_valid", 32'(out_valid), 32'd0);
        check("rst_flight_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        or_val = 1'b1;
        repeat (6) @(negedge clk);

        // Single-stage build: latency of one cycle.
        d1_in_valid = 1'b1; d1_in_a = 8'h7F; d1_in_b = 8'h01; d1_in_sub = 1'b0; d1_in_cin = 1'b0;
        #1;
        check("d1_in_ready", 32'(d1_in_ready), 32'd1);
        check("d1_idle_valid", 32'(d1_out_valid), 32'd0);
        @(negedge clk);
        d1_in_a = 8'h05; d1_in_b = 8'h07; d1_in_sub = 1'b1;
        #1;
        check("d1_lat1_valid", 32'(d1_out_valid), 32'd1);
        check("d1_add", 32'({d1_out_sum, d1_out_cout}), 32'({8'h80, 1'b0}));
`ifdef PIPELINED_ADD_SUB_FLAGS_EN
        check("d1_add_flags", 32'({d1_out_ovf, d1_out_zero, d1_out_neg}), 32'b101);
`endif
        @(negedge clk);
        d1_in_valid = 1'b0;
        #1;
        check("d1_sub", 32'({d1_out_sum, d1_out_cout}), 32'({8'hFE, 1'b0}));
        @(negedge clk);
        #1;
        check("d1_empty", 32'(d1_out_valid), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
